// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall/flush controller with halt drain sequencer (optional stall counter: HAZARD_STALL_CNT_EN).
// Latency: stall/flush outputs combinational from inputs and state; halted rises one cycle after last DRAIN cycle.
// Backpressure: a data-memory wait freezes PC, IF/ID, ID/EX and EX/MEM and defers every other event.
module hazard_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       src0_addr_ID,
  input  logic [3:0]       src1_addr_ID,
  input  logic             src0_use_ID,
  input  logic             src1_use_ID,
  input  logic             hlt_ID,
  input  logic [3:0]       dst_addr_EX,
  input  logic             re_mem_EX,
  input  logic             we_rf_EX,
  input  logic             br_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_rdy_MEM,
  output logic             stall_pc,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             stall_ID_EX,
  output logic             flush_ID_EX,
  output logic             stall_EX_MEM,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_cnt_nxt;

  logic mem_wait;
  logic load_use;
  logic src0_hit;
  logic src1_hit;

  // Raw (pre-reset-gating) control decisions.
  logic spc_c;
  logic sifid_c;
  logic fifid_c;
  logic sidex_c;
  logic fidex_c;
  logic sexmem_c;

  // Hazard detection; R0 is hardwired zero so it never creates a dependency.
  always_comb begin
    mem_wait = mem_req_MEM & ~mem_rdy_MEM;
    src0_hit = src0_use_ID & (src0_addr_ID == dst_addr_EX);
    src1_hit = src1_use_ID & (src1_addr_ID == dst_addr_EX);
    load_use = re_mem_EX & we_rf_EX & (dst_addr_EX != 4'd0) & (src0_hit | src1_hit);
  end

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state and stall/flush decode; memory wait dominates everything.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    spc_c         = 1'b0;
    sifid_c       = 1'b0;
    fifid_c       = 1'b0;
    sidex_c       = 1'b0;
    fidex_c       = 1'b0;
    sexmem_c      = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          spc_c    = 1'b1;
          sifid_c  = 1'b1;
          sidex_c  = 1'b1;
          sexmem_c = 1'b1;
        end else if (br_taken_EX) begin
          // Younger instructions are wrong-path; a HLT or load-use among them is dropped.
          fifid_c = 1'b1;
          fidex_c = 1'b1;
        end else if (load_use) begin
          spc_c   = 1'b1;
          sifid_c = 1'b1;
          fidex_c = 1'b1;
        end else if (hlt_ID) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        spc_c   = 1'b1;
        sifid_c = 1'b1;
        if (mem_wait) begin
          // Hold the back end in place; the drain count pauses too.
          sidex_c  = 1'b1;
          sexmem_c = 1'b1;
        end else begin
          fidex_c = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt = ST_HALTED;
          end else begin
            drain_cnt_nxt = drain_cnt - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        spc_c   = 1'b1;
        sifid_c = 1'b1;
        fidex_c = 1'b1;
      end
      default: begin
        state_nxt     = ST_RUN;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs forced low while reset is held so the pipeline registers see no stray control.
  always_comb begin
    stall_pc     = rst_n & spc_c;
    stall_IF_ID  = rst_n & sifid_c;
    flush_IF_ID  = rst_n & fifid_c;
    stall_ID_EX  = rst_n & sidex_c;
    flush_ID_EX  = rst_n & fidex_c;
    stall_EX_MEM = rst_n & sexmem_c;
    halted       = (state == ST_HALTED);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of PC-stall cycles spent in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state == ST_RUN) && spc_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares each cycle.
// Output order in expectations: {stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted}.
module tb_hazard_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    src0_addr_ID, src1_addr_ID, dst_addr_EX;
  logic          src0_use_ID, src1_use_ID, hlt_ID;
  logic          re_mem_EX, we_rf_EX, br_taken_EX, mem_req_MEM, mem_rdy_MEM;
  logic          stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_addr_ID(src0_addr_ID), .src1_addr_ID(src1_addr_ID),
    .src0_use_ID(src0_use_ID), .src1_use_ID(src1_use_ID), .hlt_ID(hlt_ID),
    .dst_addr_EX(dst_addr_EX), .re_mem_EX(re_mem_EX), .we_rf_EX(we_rf_EX),
    .br_taken_EX(br_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_rdy_MEM(mem_rdy_MEM),
    .stall_pc(stall_pc), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
    .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX), .stall_EX_MEM(stall_EX_MEM),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [6:0]    o;
    logic [CW-1:0] cnt;
    int unsigned   idx;
  } exp_t;

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;
  int unsigned   vec_idx = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(input logic [3:0] s0, input logic [3:0] s1, input logic u0, input logic u1,
                      input logic hlt, input logic [3:0] dst, input logic re, input logic we,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic [6:0] exp, input logic run);
    exp_t e;
    @(posedge clk);
    #1;
    src0_addr_ID = s0; src1_addr_ID = s1; src0_use_ID = u0; src1_use_ID = u1;
    hlt_ID = hlt; dst_addr_EX = dst; re_mem_EX = re; we_rf_EX = we;
    br_taken_EX = br; mem_req_MEM = mreq; mem_rdy_MEM = mrdy;
    e.o = exp; e.cnt = exp_cnt; e.idx = vec_idx;
    sb_q.push_back(e);
    vec_idx++;
    if (run && exp[6] && (exp_cnt != {CW{1'b1}})) begin
`ifdef HAZARD_STALL_CNT_EN
      exp_cnt = exp_cnt + 1'b1;
`endif
    end
  endtask

  task automatic idle(input logic [6:0] exp, input logic run);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, run);
  endtask

  task automatic zero_inputs();
    src0_addr_ID = 4'd0; src1_addr_ID = 4'd0; src0_use_ID = 1'b0; src1_use_ID = 1'b0;
    hlt_ID = 1'b0; dst_addr_EX = 4'd0; re_mem_EX = 1'b0; we_rf_EX = 1'b0;
    br_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_rdy_MEM = 1'b0;
  endtask

  task automatic reset_check(input string name);
    check({name, "_outs"}, {25'd0, stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX,
                            flush_ID_EX, stall_EX_MEM, halted}, 32'd0);
    check({name, "_cnt"}, {28'd0, stall_cnt}, 32'd0);
  endtask

  // Asynchronous reset mid-cycle, checked immediately, then released on a negedge.
  task automatic apply_reset(input string name);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    reset_check(name);
    exp_cnt = '0;
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("out_v%0d", e.idx),
              {25'd0, stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM, halted},
              {25'd0, e.o});
        check($sformatf("cnt_v%0d", e.idx), {28'd0, stall_cnt}, {28'd0, e.cnt});
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b1;
    zero_inputs();
    mem_req_MEM = 1'b1; hlt_ID = 1'b1; br_taken_EX = 1'b1;
    #2 rst_n = 1'b0;
    #2 reset_check("reset_init");
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle(7'b0000000, 1'b1);
    // Load R3 in EX, ID reads R3 on port 1: one-cycle bubble, then clear.
    step(4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100100, 1'b1);
    idle(7'b0000000, 1'b1);
    // Load to R0 read by ID: never a hazard.
    step(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // Matching address but port not used.
    step(4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // Load-use through port 0.
    step(4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100100, 1'b1);
    // ALU writer, not a load: forwarding handles it.
    step(4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // Branch with concurrent HLT and load-use: flush only, HLT dropped.
    step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0010100, 1'b1);
    idle(7'b0000000, 1'b1);
    // Four memory-wait cycles with pending branch/HLT/load-use, then the branch resolves.
    for (int i = 0; i < 4; i++)
      step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1101010, 1'b1);
    step(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'b0010100, 1'b1);
    idle(7'b0000000, 1'b1);
    // HLT: three DRAIN cycles (branch ignored), then halted held.
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    idle(7'b1100100, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100100, 1'b0);
    idle(7'b1100100, 1'b0);
    idle(7'b1100101, 1'b0);
    idle(7'b1100101, 1'b0);
    apply_reset("rst_halted");

    // HLT with a two-cycle memory wait inside DRAIN: halted two cycles later.
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    idle(7'b1100100, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1101010, 1'b0);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1101010, 1'b0);
    idle(7'b1100100, 1'b0);
    idle(7'b1100100, 1'b0);
    idle(7'b1100101, 1'b0);
    idle(7'b1100101, 1'b0);
    apply_reset("rst_halted2");

    // Reset in the middle of DRAIN returns to RUN.
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    idle(7'b1100100, 1'b0);
    apply_reset("rst_drain");
    step(4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100100, 1'b1);

    // Twenty more load-use stalls: the 4-bit counter saturates when enabled.
    for (int i = 0; i < 20; i++)
      step(4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100100, 1'b1);
    idle(7'b0000000, 1'b1);
    idle(7'b0000000, 1'b1);

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
